// File: rtl/spi_slave_fsm_if.sv
// Handshake bundle between the SPI slave sequencer and its conditioner/datapath neighbours.
// "master" drives the conditioned inputs; "slave" is the sequencer side.
interface spi_slave_fsm_if;
    logic cs_cond;
    logic sclk_posedge;
    logic sclk_negedge;
    logic rw_bit;
    logic sr_shift_en;
    logic sr_load;
    logic addr_we;
    logic dm_we;
    logic miso_buff_en;
    logic busy;

    modport master (
        output cs_cond, sclk_posedge, sclk_negedge, rw_bit,
        input  sr_shift_en, sr_load, addr_we, dm_we, miso_buff_en, busy
    );

    modport slave (
        input  cs_cond, sclk_posedge, sclk_negedge, rw_bit,
        output sr_shift_en, sr_load, addr_we, dm_we, miso_buff_en, busy
    );
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI slave transaction sequencer: one address byte (R/W in LSB) then one data byte per CS frame.
// Outputs are combinational decodes of the registered state and the current input pulses.
module spi_slave_fsm #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input logic            clk,
    input logic            reset_n,
    spi_slave_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRxAddr,
        StAddrDone,
        StRdLoad,
        StRdShift,
        StWrRecv,
        StWrCommit,
        StDone
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LastBit = CNT_WIDTH'(DATA_WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic sr_shift_en, sr_load, addr_we, dm_we, miso_buff_en;
    logic byte_done;

    // Final bit of a byte: clear the counter here so it never wraps or exceeds DATA_WIDTH.
    assign byte_done = bus.sclk_posedge && (cnt_q == LastBit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_shift_en  = 1'b0;
        sr_load      = 1'b0;
        addr_we      = 1'b0;
        dm_we        = 1'b0;
        miso_buff_en = 1'b0;

        if (state_q != StIdle && bus.cs_cond) begin
            // CS deasserted mid-frame: abort with every strobe suppressed, including a pending commit.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!bus.cs_cond) begin
                        state_d = StRxAddr;
                        cnt_d   = '0;
                    end
                end
                StRxAddr: begin
                    sr_shift_en = bus.sclk_posedge;
                    if (byte_done) begin
                        state_d = StAddrDone;
                        cnt_d   = '0;
                    end else if (bus.sclk_posedge) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StAddrDone: begin
                    addr_we = 1'b1;
                    cnt_d   = '0;
                    state_d = bus.rw_bit ? StRdLoad : StWrRecv;
                end
                StRdLoad: begin
                    sr_load      = 1'b1;
                    miso_buff_en = 1'b1;
                    state_d      = StRdShift;
                end
                StRdShift: begin
                    miso_buff_en = 1'b1;
                    // Simultaneous edges are illegal; the posedge wins and the negedge is dropped.
                    sr_shift_en  = bus.sclk_negedge && !bus.sclk_posedge;
                    if (byte_done) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else if (bus.sclk_posedge) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWrRecv: begin
                    sr_shift_en = bus.sclk_posedge;
                    if (byte_done) begin
                        state_d = StWrCommit;
                        cnt_d   = '0;
                    end else if (bus.sclk_posedge) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWrCommit: begin
                    dm_we   = 1'b1;
                    state_d = StDone;
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.sr_shift_en  = sr_shift_en;
    assign bus.sr_load      = sr_load;
    assign bus.addr_we      = addr_we;
    assign bus.dm_we        = dm_we;
    assign bus.miso_buff_en = miso_buff_en;
    assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: a frame-level model queues expected strobe events,
// a negedge monitor pops and compares them whenever any strobe fires.
module tb_spi_slave_fsm;

    localparam int unsigned DW = 8;

    // Event encoding: {sr_shift_en, sr_load, addr_we, dm_we, miso_buff_en}
    localparam logic [4:0] EvShiftWr = 5'b10000;
    localparam logic [4:0] EvShiftRd = 5'b10001;
    localparam logic [4:0] EvAwe     = 5'b00100;
    localparam logic [4:0] EvLoad    = 5'b01001;
    localparam logic [4:0] EvDwe     = 5'b00010;

    localparam int KindPos  = 0;
    localparam int KindNeg  = 1;
    localparam int KindBoth = 2;

    logic clk = 1'b0;
    logic reset_n;

    spi_slave_fsm_if bus ();

    spi_slave_fsm #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [4:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // Frame-level reference model state
    bit m_active;
    bit m_addr_done;
    bit m_done;
    bit m_rw;
    bit m_commit_due;
    int m_bits;

    logic [4:0] mon_obs;
    logic [4:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            mon_obs = {bus.sr_shift_en, bus.sr_load, bus.addr_we, bus.dm_we, bus.miso_buff_en};
            if (mon_obs[4:1] != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got %b, expected no strobe (t=%0t)",
                             mon_obs, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("strobe_event", 32'(mon_obs), 32'(mon_exp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic gap();
        idle($urandom_range(3, 6));
    endtask

    task automatic model_start(input bit rw);
        m_active     = 1'b1;
        m_addr_done  = 1'b0;
        m_done       = 1'b0;
        m_rw         = rw;
        m_commit_due = 1'b0;
        m_bits       = 0;
    endtask

    // One SCLK edge pulse; the model decides which strobes that edge must produce.
    task automatic pulse(input int kind);
        if (m_active) begin
            if (kind != KindNeg) begin
                if (!m_addr_done) begin
                    exp_q.push_back(EvShiftWr);
                    m_bits++;
                    if (m_bits == DW) begin
                        exp_q.push_back(EvAwe);
                        if (m_rw) exp_q.push_back(EvLoad);
                        m_addr_done = 1'b1;
                        m_bits      = 0;
                    end
                end else if (!m_done) begin
                    if (!m_rw) exp_q.push_back(EvShiftWr);
                    m_bits++;
                    if (m_bits == DW) begin
                        m_done       = 1'b1;
                        m_commit_due = !m_rw;
                    end
                end
            end
            if (kind == KindNeg && m_addr_done && !m_done && m_rw) exp_q.push_back(EvShiftRd);
        end
        bus.sclk_posedge = (kind != KindNeg);
        bus.sclk_negedge = (kind != KindPos);
        tick();
        bus.sclk_posedge = 1'b0;
        bus.sclk_negedge = 1'b0;
    endtask

    function automatic int rising_kind();
        return ($urandom_range(0, 5) == 0) ? KindBoth : KindPos;
    endfunction

    task automatic frame(input bit rw, input int n_addr, input int n_data, input bit abort_commit);
        bit cut;
        cut = 1'b0;
        model_start(rw);
        bus.rw_bit  = rw;
        bus.cs_cond = 1'b0;
        idle(3);
        for (int i = 0; i < n_addr; i++) begin
            pulse(rising_kind());
            if (i == 0) check("busy_mid_frame", 32'(bus.busy), 32'd1);
            gap();
            pulse(KindNeg);
            gap();
        end
        if (n_addr == DW) begin
            for (int i = 0; i < n_data && !cut; i++) begin
                pulse(rising_kind());
                if (m_commit_due && abort_commit) begin
                    // CS rises in the commit cycle itself: the write must be dropped.
                    bus.cs_cond  = 1'b1;
                    m_commit_due = 1'b0;
                    cut          = 1'b1;
                end else begin
                    if (m_commit_due) exp_q.push_back(EvDwe);
                    m_commit_due = 1'b0;
                    gap();
                    pulse(KindNeg);
                    gap();
                end
            end
        end
        bus.cs_cond = 1'b1;
        m_active    = 1'b0;
        idle(3);
        check("busy_after_frame", 32'(bus.busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cs_cond      = 1'b1;
        bus.sclk_posedge = 1'b0;
        bus.sclk_negedge = 1'b0;
        bus.rw_bit       = 1'b0;
        m_active         = 1'b0;
        reset_n          = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_outputs", 32'({bus.sr_shift_en, bus.sr_load, bus.addr_we, bus.dm_we,
                                     bus.miso_buff_en}), 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // Directed: write, read, aborted write + recovery, overlong write, commit-cycle abort
        frame(1'b0, DW, DW, 1'b0);
        frame(1'b1, DW, DW, 1'b0);
        frame(1'b0, DW, 5, 1'b0);
        frame(1'b0, DW, DW, 1'b0);
        frame(1'b0, DW, 12, 1'b0);
        frame(1'b1, DW, 12, 1'b0);
        frame(1'b0, DW, DW, 1'b1);
        frame(1'b1, 5, 0, 1'b0);

        // CS held high: SCLK activity must be ignored
        for (int i = 0; i < 10; i++) begin
            pulse($urandom_range(0, 2));
            idle(1);
        end
        check("idle_cs_high_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid address byte
        model_start(1'b0);
        bus.cs_cond = 1'b0;
        idle(3);
        for (int i = 0; i < 3; i++) begin
            pulse(KindPos);
            gap();
        end
        check("busy_before_reset", 32'(bus.busy), 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(bus.busy), 32'd0);
        check("async_reset_outputs", 32'({bus.sr_shift_en, bus.sr_load, bus.addr_we, bus.dm_we,
                                           bus.miso_buff_en}), 32'd0);
        m_active    = 1'b0;
        bus.cs_cond = 1'b1;
        idle(1);
        pulse(KindPos);
        @(negedge clk);
        #2 reset_n = 1'b1;
        idle(2);
        for (int i = 0; i < 4; i++) pulse(KindPos);
        idle(2);
        check("post_reset_busy", 32'(bus.busy), 32'd0);
        check("post_reset_queue", 32'(exp_q.size()), 32'd0);
        frame(1'b0, DW, DW, 1'b0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            bit rw;
            int n_addr;
            int n_data;
            bit ab;
            rw     = 1'($urandom_range(0, 1));
            n_addr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, DW - 1)) : int'(DW);
            n_data = int'($urandom_range(0, 12));
            ab     = !rw && ($urandom_range(0, 4) == 0);
            frame(rw, n_addr, n_data, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
